rram_imc_seq_ctrl: RTL and testbench

//  Wishbone-programmed sequencer for the RRAM in-memory-compute array.

---
 rtl/rram_imc_seq_ctrl_if.sv | 19 +
 rtl/rram_imc_seq_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_rram_imc_seq_ctrl.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rram_imc_seq_ctrl_if.sv
// Wishbone slave bus bundle for the RRAM IMC sequencer.
//   wishbone_address_bus : byte address, bits [4:2] select the register
//   wishbone_data_in     : write data
//   wbs_we_i / wbs_stb_i : write enable / request (stb&cyc pre-combined)
//   wishbone_data_out    : read data, valid while wbs_ack_o is high
//   wbs_ack_o            : single-cycle acknowledge
interface rram_imc_seq_ctrl_if;
  logic [31:0] wishbone_address_bus;
  logic [31:0] wishbone_data_in;
  logic        wbs_we_i;
  logic        wbs_stb_i;
  logic [31:0] wishbone_data_out;
  logic        wbs_ack_o;

  modport master (output wishbone_address_bus, wishbone_data_in, wbs_we_i, wbs_stb_i,
                  input  wishbone_data_out, wbs_ack_o);
  modport slave  (input  wishbone_address_bus, wishbone_data_in, wbs_we_i, wbs_stb_i,
                  output wishbone_data_out, wbs_ack_o);
endinterface

// File: rtl/rram_imc_seq_ctrl.sv
// Wishbone-programmed sequencer for the RRAM in-memory-compute array.
// Runs READ / SET / RESET on one row, or MAC on a row vector, timing the
// precharge, WL/column activation and sense phases and capturing CSA/ADC data.
//   clk, rst          : clock, asynchronous active-low reset
//   enable_IM         : global enable, low aborts any running operation
//   wb (slave)        : register bus (CTRL, COLMASK, INVEC, STATUS, RESULT)
//   csa_in, adc_in    : sense-amp and flash-ADC results from the macro
//   wl_en, col_en     : word-line / column drive enables
//   wr_pol            : 0 = SET, 1 = RESET programming polarity
//   pre_en, sense_en  : precharge switch, one-cycle sample strobe
//   busy, done_irq    : op in progress, one-cycle completion pulse
module rram_imc_seq_ctrl #(
  parameter int ROWS  = 16,
  parameter int COLS  = 16,
  parameter int T_PRE = 4,
  parameter int T_RD  = 8,
  parameter int T_WR  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable_IM,
  rram_imc_seq_ctrl_if.slave  wb,
  input  logic [COLS-1:0]     csa_in,
  input  logic [2:0]          adc_in,
  output logic [ROWS-1:0]     wl_en,
  output logic [COLS-1:0]     col_en,
  output logic                wr_pol,
  output logic                pre_en,
  output logic                sense_en,
  output logic                busy,
  output logic                done_irq
);
  localparam logic [1:0] OP_READ = 2'b00, OP_SET = 2'b01, OP_RST = 2'b10, OP_MAC = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_ACT, S_SAMPLE, S_FIN} state_t;

  state_t          r_state, w_state_nxt;
  logic [7:0]      r_cnt, w_ld_val;
  logic            w_ld;
  logic            r_ack;
  logic [31:0]     r_rdata, w_rmux;
  logic [1:0]      r_op;
  logic [3:0]      r_row;
  logic [COLS-1:0] r_colmask, r_res_csa;
  logic [ROWS-1:0] r_invec;
  logic [2:0]      r_res_adc;
  logic            r_done, r_err;
  // Operation parameters frozen at start so later register writes cannot disturb a running op
  logic [1:0]      r_lop;
  logic [3:0]      r_lrow;
  logic [COLS-1:0] r_lcol;
  logic [ROWS-1:0] r_linvec;

  logic [2:0]      w_sel;
  logic            w_wr, w_rd, w_start, w_start_ok, w_go, w_abort, w_fin_exit;
  logic [1:0]      w_lop_n;
  logic [3:0]      w_lrow_n;
  logic [COLS-1:0] w_lcol_n;
  logic [ROWS-1:0] w_linvec_n;
  logic            w_unused;

  assign w_unused = &{1'b0, wb.wishbone_address_bus[31:5], wb.wishbone_address_bus[1:0],
                      wb.wishbone_data_in};

  assign w_sel = wb.wishbone_address_bus[4:2];
  // Accept a request only when no ack is pending, so stb held high acks every other cycle
  assign w_wr  = wb.wbs_stb_i &  wb.wbs_we_i & ~r_ack;
  assign w_rd  = wb.wbs_stb_i & ~wb.wbs_we_i & ~r_ack;
  assign w_start = w_wr && (w_sel == 3'd0) && wb.wishbone_data_in[8];
  assign w_start_ok = (r_state == S_IDLE) && enable_IM && (r_colmask != '0) &&
                      !((wb.wishbone_data_in[1:0] == OP_MAC) && (r_invec == '0)) &&
                      ({28'd0, wb.wishbone_data_in[7:4]} < 32'(ROWS));
  assign w_go       = w_start && w_start_ok;
  assign w_abort    = (r_state != S_IDLE) && !enable_IM;
  assign w_fin_exit = (r_state == S_FIN) && enable_IM;

  // On the start edge the drives must come from the values being latched, not the stale ones
  assign w_lop_n    = w_go ? wb.wishbone_data_in[1:0] : r_lop;
  assign w_lrow_n   = w_go ? wb.wishbone_data_in[7:4] : r_lrow;
  assign w_lcol_n   = w_go ? r_colmask : r_lcol;
  assign w_linvec_n = w_go ? r_invec   : r_linvec;

  always_comb begin
    w_state_nxt = r_state;
    w_ld        = 1'b0;
    w_ld_val    = '0;
    case (r_state)
      S_IDLE: if (w_go) begin
        w_ld = 1'b1;
        if (w_lop_n == OP_SET || w_lop_n == OP_RST) begin
          w_state_nxt = S_ACT;
          w_ld_val    = 8'(T_WR - 1);
        end else begin
          w_state_nxt = S_PRE;
          w_ld_val    = 8'(T_PRE - 1);
        end
      end
      S_PRE: if (r_cnt == '0) begin
        w_state_nxt = S_ACT;
        w_ld        = 1'b1;
        w_ld_val    = 8'(T_RD - 1);
      end
      S_ACT: if (r_cnt == '0)
        w_state_nxt = (r_lop == OP_SET || r_lop == OP_RST) ? S_FIN : S_SAMPLE;
      S_SAMPLE: w_state_nxt = S_FIN;
      S_FIN:    w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
    if (w_abort) w_state_nxt = S_IDLE;
  end

  // Drives are registered from the next state so every enable comes straight off a flop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      wl_en    <= '0;
      col_en   <= '0;
      wr_pol   <= 1'b0;
      pre_en   <= 1'b0;
      sense_en <= 1'b0;
      busy     <= 1'b0;
      done_irq <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_ld)              r_cnt <= w_ld_val;
      else if (r_cnt != '0)  r_cnt <= r_cnt - 8'd1;
      pre_en   <= (w_state_nxt == S_PRE);
      sense_en <= (w_state_nxt == S_SAMPLE);
      done_irq <= (w_state_nxt == S_FIN);
      busy     <= (w_state_nxt != S_IDLE);
      wr_pol   <= (w_state_nxt == S_ACT) && (w_lop_n == OP_RST);
      col_en   <= (w_state_nxt == S_ACT) ? w_lcol_n : '0;
      if (w_state_nxt == S_ACT)
        wl_en <= (w_lop_n == OP_MAC) ? w_linvec_n : (ROWS'(1) << w_lrow_n);
      else
        wl_en <= '0;
    end
  end

  always_comb begin
    w_rmux = '0;
    case (w_sel)
      3'd0: begin w_rmux[1:0] = r_op; w_rmux[7:4] = r_row; end
      3'd1: w_rmux[COLS-1:0] = r_colmask;
      3'd2: w_rmux[ROWS-1:0] = r_invec;
      3'd3: w_rmux[2:0] = {r_err, r_done, busy};
      3'd4: begin w_rmux[COLS-1:0] = r_res_csa; w_rmux[18:16] = r_res_adc; end
      default: w_rmux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ack <= 1'b0; r_rdata <= '0;
      r_op <= '0; r_row <= '0; r_colmask <= '0; r_invec <= '0;
      r_done <= 1'b0; r_err <= 1'b0; r_res_csa <= '0; r_res_adc <= '0;
      r_lop <= '0; r_lrow <= '0; r_lcol <= '0; r_linvec <= '0;
    end else begin
      r_ack   <= wb.wbs_stb_i & ~r_ack;
      r_rdata <= w_rd ? w_rmux : '0;
      if (w_wr) begin
        case (w_sel)
          3'd0: begin r_op <= wb.wishbone_data_in[1:0]; r_row <= wb.wishbone_data_in[7:4]; end
          3'd1: r_colmask <= wb.wishbone_data_in[COLS-1:0];
          3'd2: r_invec   <= wb.wishbone_data_in[ROWS-1:0];
          3'd3: begin
            if (wb.wishbone_data_in[1]) r_done <= 1'b0;
            if (wb.wishbone_data_in[2]) r_err  <= 1'b0;
          end
          default: ;
        endcase
      end
      if (w_go) begin
        r_lop <= w_lop_n; r_lrow <= w_lrow_n; r_lcol <= w_lcol_n; r_linvec <= w_linvec_n;
        r_done <= 1'b0;
      end
      if (w_fin_exit) r_done <= 1'b1;
      if ((w_start && !w_start_ok) || w_abort) r_err <= 1'b1;
      if (r_state == S_SAMPLE && enable_IM) begin
        if (r_lop == OP_MAC) r_res_adc <= adc_in;
        else                 r_res_csa <= csa_in;
      end
    end
  end

  assign wb.wbs_ack_o         = r_ack;
  assign wb.wishbone_data_out = r_rdata;
endmodule

// File: tb/tb_rram_imc_seq_ctrl.sv
// Directed bench for rram_imc_seq_ctrl: register vector table plus hand-written
// operation, error, abort and asynchronous-reset sequences.
module tb_rram_imc_seq_ctrl;
  localparam int ROWS = 16, COLS = 16, NK = 24;

  logic            clk = 1'b0;
  logic            rst, enable_IM;
  logic [COLS-1:0] csa_in;
  logic [2:0]      adc_in;
  logic [ROWS-1:0] wl_en;
  logic [COLS-1:0] col_en;
  logic            wr_pol, pre_en, sense_en, busy, done_irq;

  rram_imc_seq_ctrl_if wb();

  rram_imc_seq_ctrl #(.ROWS(ROWS), .COLS(COLS), .T_PRE(4), .T_RD(8), .T_WR(16)) dut (
    .clk(clk), .rst(rst), .enable_IM(enable_IM), .wb(wb.slave),
    .csa_in(csa_in), .adc_in(adc_in), .wl_en(wl_en), .col_en(col_en),
    .wr_pol(wr_pol), .pre_en(pre_en), .sense_en(sense_en), .busy(busy), .done_irq(done_irq));

  always #5 clk = ~clk;

  localparam logic [31:0] A_CTRL = 32'h00, A_COL = 32'h04, A_INV = 32'h08,
                          A_STAT = 32'h0C, A_RES = 32'h10, A_BAD = 32'h14;

  int n_tests = 0, n_fail = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[16];

  // per-cycle history; index k = k-th cycle after the start edge
  logic [15:0] h_wl[1:NK], h_col[1:NK];
  logic        h_pre[1:NK], h_sns[1:NK], h_irq[1:NK], h_busy[1:NK], h_pol[1:NK];
  int t_pre, t_wl, t_wl1, t_sns, t_ksns, t_irq, t_kirq, t_busy, t_pol, t_ovl, t_bad;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic wb_wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    wb.wishbone_address_bus = a; wb.wishbone_data_in = d;
    wb.wbs_we_i = 1'b1; wb.wbs_stb_i = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    wb.wbs_stb_i = 1'b0; wb.wbs_we_i = 1'b0;
  endtask

  task automatic wb_rd(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    wb.wishbone_address_bus = a; wb.wbs_we_i = 1'b0; wb.wbs_stb_i = 1'b1;
    @(posedge clk); #1;
    d = wb.wishbone_data_out;
    @(negedge clk);
    wb.wbs_stb_i = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    wb_rd(a, d);
    chk(nm, d, exp);
  endtask

  // called at the negedge of cycle 1 after the start edge
  task automatic capture();
    for (int k = 1; k <= NK; k++) begin
      if (k > 1) @(negedge clk);
      h_wl[k] = wl_en; h_col[k] = col_en; h_pre[k] = pre_en; h_sns[k] = sense_en;
      h_irq[k] = done_irq; h_busy[k] = busy; h_pol[k] = wr_pol;
    end
  endtask

  task automatic tally(input logic [15:0] wl_x, input logic [15:0] col_x);
    t_pre = 0; t_wl = 0; t_wl1 = 0; t_sns = 0; t_ksns = 0; t_irq = 0; t_kirq = 0;
    t_busy = 0; t_pol = 0; t_ovl = 0; t_bad = 0;
    for (int k = 1; k <= NK; k++) begin
      if (h_pre[k]) t_pre++;
      if (h_wl[k] == wl_x && h_col[k] == col_x) begin
        t_wl++;
        if (t_wl1 == 0) t_wl1 = k;
      end else if (h_wl[k] != 16'h0 || h_col[k] != 16'h0) t_bad++;
      if (h_sns[k]) begin t_sns++; t_ksns = k; end
      if (h_irq[k]) begin t_irq++; t_kirq = k; end
      if (h_busy[k]) t_busy++;
      if (h_pol[k]) t_pol++;
      if (h_pre[k] && h_wl[k] != 16'h0) t_ovl++;
    end
  endtask

  initial begin
    logic [31:0] d;
    int acks, nirq, nwl, ncolbad;

    rst = 1'b0; enable_IM = 1'b1; csa_in = '0; adc_in = '0;
    wb.wishbone_address_bus = '0; wb.wishbone_data_in = '0;
    wb.wbs_we_i = 1'b0; wb.wbs_stb_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {wl_en, col_en}, 32'h0);
    chk("reset_ctrl_bits", {26'd0, wr_pol, pre_en, sense_en, busy, done_irq, wb.wbs_ack_o}, 32'h0);
    rst = 1'b1;

    // ---------------- register table ----------------
    vecs[0]  = '{1'b0, A_CTRL, 32'h0, 32'h0};
    vecs[1]  = '{1'b0, A_COL,  32'h0, 32'h0};
    vecs[2]  = '{1'b0, A_INV,  32'h0, 32'h0};
    vecs[3]  = '{1'b0, A_STAT, 32'h0, 32'h0};
    vecs[4]  = '{1'b0, A_RES,  32'h0, 32'h0};
    vecs[5]  = '{1'b1, A_COL,  32'hFFFF1234, 32'h0};
    vecs[6]  = '{1'b0, A_COL,  32'h0, 32'h00001234};
    vecs[7]  = '{1'b1, A_INV,  32'h0000ABCD, 32'h0};
    vecs[8]  = '{1'b0, A_INV,  32'h0, 32'h0000ABCD};
    vecs[9]  = '{1'b1, A_CTRL, 32'h000000F1, 32'h0};
    vecs[10] = '{1'b0, A_CTRL, 32'h0, 32'h000000F1};
    vecs[11] = '{1'b1, A_BAD,  32'hFFFFFFFF, 32'h0};
    vecs[12] = '{1'b0, A_BAD,  32'h0, 32'h0};
    vecs[13] = '{1'b1, A_RES,  32'hFFFFFFFF, 32'h0};
    vecs[14] = '{1'b0, A_RES,  32'h0, 32'h0};
    vecs[15] = '{1'b0, A_STAT, 32'h0, 32'h0};
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].we) wb_wr(vecs[i].addr, vecs[i].wdata);
      else rd_chk($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
    end

    // stb held high: ack every other cycle
    @(negedge clk);
    wb.wishbone_address_bus = A_STAT; wb.wbs_we_i = 1'b0; wb.wbs_stb_i = 1'b1;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (wb.wbs_ack_o) acks++;
    end
    @(negedge clk); wb.wbs_stb_i = 1'b0;
    chk("ack_alternate", acks, 2);

    // ---------------- READ row 3 ----------------
    wb_wr(A_COL, 32'h00FF);
    csa_in = 16'hA5A5;
    wb_wr(A_CTRL, 32'h130);
    capture();
    tally(16'h0008, 16'h00FF);
    chk("rd_pre_cycles", t_pre, 4);
    chk("rd_pre_first", {31'd0, h_pre[1]}, 1);
    chk("rd_wl_cycles", t_wl, 8);
    chk("rd_wl_first", t_wl1, 5);
    chk("rd_stray_drive", t_bad, 0);
    chk("rd_sense_at", {t_sns, t_ksns}, {32'd1, 32'd13});
    chk("rd_irq_at", {t_irq, t_kirq}, {32'd1, 32'd14});
    chk("rd_busy_cycles", t_busy, 14);
    chk("rd_overlap", t_ovl, 0);
    chk("rd_pol", t_pol, 0);
    rd_chk("rd_result", A_RES, 32'h0000A5A5);
    rd_chk("rd_status", A_STAT, 32'h2);
    rd_chk("rd_ctrl_start_clear", A_CTRL, 32'h30);

    // ---------------- RESET row 15 ----------------
    wb_wr(A_COL, 32'h8001);
    wb_wr(A_CTRL, 32'h1F2);
    capture();
    tally(16'h8000, 16'h8001);
    chk("rs_pre_cycles", t_pre, 0);
    chk("rs_wl_cycles", t_wl, 16);
    chk("rs_wl_first", t_wl1, 1);
    chk("rs_pol_cycles", t_pol, 16);
    chk("rs_stray_drive", t_bad, 0);
    chk("rs_sense", t_sns, 0);
    chk("rs_irq_at", {t_irq, t_kirq}, {32'd1, 32'd17});
    chk("rs_busy_cycles", t_busy, 17);
    rd_chk("rs_status", A_STAT, 32'h2);
    rd_chk("rs_result_kept", A_RES, 32'h0000A5A5);

    // ---------------- MAC ----------------
    wb_wr(A_COL, 32'h00FF);
    wb_wr(A_INV, 32'h0F0F);
    adc_in = 3'b101; csa_in = 16'h1111;
    wb_wr(A_CTRL, 32'h103);
    capture();
    tally(16'h0F0F, 16'h00FF);
    chk("mac_pre_cycles", t_pre, 4);
    chk("mac_wl_cycles", t_wl, 8);
    chk("mac_wl_first", t_wl1, 5);
    chk("mac_stray_drive", t_bad, 0);
    chk("mac_sense_at", {t_sns, t_ksns}, {32'd1, 32'd13});
    chk("mac_irq_at", {t_irq, t_kirq}, {32'd1, 32'd14});
    rd_chk("mac_result", A_RES, 32'h0005A5A5);

    // ---------------- errors ----------------
    csa_in = 16'h3C3C;
    wb_wr(A_CTRL, 32'h130);      // READ row 3, COLMASK 0x00FF
    wb_wr(A_CTRL, 32'h130);      // start while busy
    wb_wr(A_COL, 32'h0);         // must not affect the running op
    nirq = 0; nwl = 0; ncolbad = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done_irq) nirq++;
      if (wl_en != 16'h0) begin
        nwl++;
        if (wl_en != 16'h0008 || col_en != 16'h00FF) ncolbad++;
      end
    end
    chk("err_run_irq", nirq, 1);
    chk("err_run_wl", nwl, 7);   // cycles k=6..12 after the first start fall in this window
    chk("err_run_latched", ncolbad, 0);
    rd_chk("err_busy_status", A_STAT, 32'h6);
    rd_chk("err_run_result", A_RES, 32'h00053C3C);
    wb_wr(A_STAT, 32'h6);
    rd_chk("err_clear_all", A_STAT, 32'h0);
    wb_wr(A_CTRL, 32'h130);      // COLMASK == 0
    chk("err_col0_busy", {31'd0, busy}, 0);
    rd_chk("err_col0_status", A_STAT, 32'h4);
    wb_wr(A_STAT, 32'h4);
    rd_chk("err_clear", A_STAT, 32'h0);
    wb_wr(A_COL, 32'h00FF);
    enable_IM = 1'b0;
    wb_wr(A_CTRL, 32'h130);
    chk("err_dis_busy", {31'd0, busy}, 0);
    enable_IM = 1'b1;
    rd_chk("err_dis_status", A_STAT, 32'h4);
    wb_wr(A_STAT, 32'h4);
    wb_wr(A_INV, 32'h0);
    wb_wr(A_CTRL, 32'h103);
    chk("err_inv0_busy", {31'd0, busy}, 0);
    rd_chk("err_inv0_status", A_STAT, 32'h4);
    wb_wr(A_STAT, 32'h4);

    // ---------------- abort at ACT cycle 3 ----------------
    csa_in = 16'h7777;
    wb_wr(A_CTRL, 32'h130);
    for (int k = 1; k <= NK; k++) begin
      if (k > 1) @(negedge clk);
      h_wl[k] = wl_en; h_col[k] = col_en; h_pre[k] = pre_en; h_sns[k] = sense_en;
      h_irq[k] = done_irq; h_busy[k] = busy; h_pol[k] = wr_pol;
      if (k == 7) enable_IM = 1'b0;
    end
    enable_IM = 1'b1;
    tally(16'h0008, 16'h00FF);
    chk("ab_act3_wl", {16'd0, h_wl[7]}, 32'h0008);
    chk("ab_next_drives", {h_wl[8], h_col[8]}, 32'h0);
    chk("ab_next_busy", {30'd0, h_busy[8], h_pre[8]}, 0);
    chk("ab_wl_cycles", t_wl, 3);
    chk("ab_no_irq_sense", {t_irq, t_sns}, 64'h0);
    rd_chk("ab_status", A_STAT, 32'h4);
    rd_chk("ab_result", A_RES, 32'h00053C3C);
    wb_wr(A_STAT, 32'h4);

    // ---------------- async reset mid-ACT ----------------
    wb_wr(A_CTRL, 32'h130);
    repeat (5) @(negedge clk);   // cycle 6 after start: ACT
    chk("rst_pre_wl", {16'd0, wl_en}, 32'h0008);
    #2 rst = 1'b0;
    #1;
    chk("rst_async_drives", {wl_en, col_en}, 32'h0);
    chk("rst_async_ctrl", {30'd0, pre_en, busy}, 0);
    @(negedge clk);
    rst = 1'b1;
    rd_chk("rst_ctrl", A_CTRL, 32'h0);
    rd_chk("rst_col", A_COL, 32'h0);
    rd_chk("rst_inv", A_INV, 32'h0);
    rd_chk("rst_stat", A_STAT, 32'h0);
    rd_chk("rst_res", A_RES, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
